// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module      : fetch_unit_if
// Description : Bus between the multicycle control FSM and the fetch unit.
//               Perf counter signals exist only when FETCH_PERF_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
    logic [3:0]  State;
    logic [31:0] MemData;
    logic        Zero;
    logic [31:0] PC;
    logic [31:0] IR;
    logic [5:0]  Opcode;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [31:0] Imm;
    logic [31:0] BranchTarget;
`ifdef FETCH_PERF_EN
    logic [31:0] InstrCount;
    logic [31:0] CycleCount;

    modport master (
        output State, MemData, Zero,
        input  PC, IR, Opcode, Rs, Rt, Rd, Imm, BranchTarget,
        input  InstrCount, CycleCount
    );

    modport slave (
        input  State, MemData, Zero,
        output PC, IR, Opcode, Rs, Rt, Rd, Imm, BranchTarget,
        output InstrCount, CycleCount
    );
`else
    modport master (
        output State, MemData, Zero,
        input  PC, IR, Opcode, Rs, Rt, Rd, Imm, BranchTarget
    );

    modport slave (
        input  State, MemData, Zero,
        output PC, IR, Opcode, Rs, Rt, Rd, Imm, BranchTarget
    );
`endif
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : fetch_unit
// Description : PC / IR / branch-target datapath sequenced by the control FSM.
//               Optional macro FETCH_PERF_EN adds instruction and cycle counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic   Clk,
    input  wire logic   Reset,
    fetch_unit_if.slave bus
);

    localparam logic [3:0] c_ST_FETCH  = 4'd0;
    localparam logic [3:0] c_ST_DECODE = 4'd1;
    localparam logic [3:0] c_ST_BEQ    = 4'd8;
    localparam logic [3:0] c_ST_JUMP   = 4'd9;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] bt_q, bt_d;
    logic [31:0] w_imm;

    assign w_imm = {{16{ir_q[15]}}, ir_q[15:0]};

    // Every state not listed (2-7 and the undefined 10-15) holds all registers.
    always_comb begin
        pc_d = pc_q;
        ir_d = ir_q;
        bt_d = bt_q;
        case (bus.State)
            c_ST_FETCH: begin
                ir_d = bus.MemData;
                pc_d = pc_q + 32'd4;
            end
            c_ST_DECODE: begin
                bt_d = pc_q + {w_imm[29:0], 2'b00};
            end
            c_ST_BEQ: begin
                if (bus.Zero) begin
                    pc_d = bt_q;
                end
            end
            c_ST_JUMP: begin
                pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q <= RESET_PC;
            ir_q <= 32'd0;
            bt_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
            bt_q <= bt_d;
        end
    end

    assign bus.PC           = pc_q;
    assign bus.IR           = ir_q;
    assign bus.Opcode       = ir_q[31:26];
    assign bus.Rs           = ir_q[25:21];
    assign bus.Rt           = ir_q[20:16];
    assign bus.Rd           = ir_q[15:11];
    assign bus.Imm          = w_imm;
    assign bus.BranchTarget = bt_q;

`ifdef FETCH_PERF_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q;
        if (bus.State == c_ST_FETCH) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_cnt_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.InstrCount = instr_cnt_q;
    assign bus.CycleCount = cycle_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-side datapath partner of the multicycle control FSM. Consumes the 4-bit `State` the FSM produces and supplies the `Opcode` it decodes. Holds the program counter (PC), instruction register (IR) and branch-target register. Performs fetch, PC increment, branch and jump updates in the states the FSM sequences, and presents decoded IR fields to the register file and ALU.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `Clk`  input  1: clock; all registers update on the rising edge.
- `Reset`  input  1: synchronous, active-high reset.
- `State`  input  4: current FSM state (0..9 defined).
- `MemData`  input  32: instruction word read from memory at address `PC`; valid combinationally during state 0.
- `Zero`  input  1: ALU equality result; valid during state 8.
- `PC`  output  32: program counter; also the instruction memory address.
- `IR`  output  32: instruction register.
- `Opcode`  output  6: `IR[31:26]`, wired to the FSM.
- `Rs` / `Rt` / `Rd`  output  5 each: `IR[25:21]` / `IR[20:16]` / `IR[15:11]`.
- `Imm`  output  32: sign-extended `IR[15:0]`.
- `BranchTarget`  output  32: latched branch target.
- `InstrCount`  output  32: fetched-instruction count (only with `FETCH_PERF_EN`).
- `CycleCount`  output  32: cycles since reset (only with `FETCH_PERF_EN`).

## Operation
- State 0 (fetch):
  - `IR <= MemData`.
  - `PC <= PC + 32'd4`.
- State 1 (decode):
  - `BranchTarget <= PC + (Imm << 2)`.
  - The PC used here is already incremented; `Imm` is from the newly loaded IR.
- State 8 (BEQ):
  - If `Zero == 1`: `PC <= BranchTarget`.
  - Otherwise PC holds.
- State 9 (J): `PC <= {PC[31:28], IR[25:0], 2'b00}`, using the upper bits of the incremented PC.
- States 2–7: PC, IR and BranchTarget hold.
- State values 10–15: treated as no-op. All registers hold; no X propagation.
- Combinational field outputs (`Opcode`, `Rs`, `Rt`, `Rd`, `Imm`) are pure slices or sign extensions of `IR`.
- All PC arithmetic is 32-bit modulo 2^32:
  - `PC = 32'hFFFF_FFFC` in state 0 wraps to `32'h0000_0000`.
  - Negative branch offsets wrap likewise.
- No alignment check; PC bits [1:0] stay 0 only if `RESET_PC` is word-aligned.

## Timing
- Reset has priority over every state action. On the first edge with `Reset = 1`:
  - `PC = RESET_PC`; `IR = 0` (so `Opcode = 0`); `BranchTarget = 0`.
  - `InstrCount = 0`; `CycleCount = 0`.
- Reset asserted mid-instruction (any state) aborts that instruction; no partial PC update occurs on that edge.
- Latency: every update listed above is visible one edge after the cycle in which `State` holds the triggering value.
- The IR from a fetch is stable by the time the FSM samples `Opcode` in state 1, and stays stable until the next state 0.
- `MemData` and `Zero` are sampled only on the edge ending states 0 and 8 respectively; they are don't-care otherwise.
- Fixed sequences for consecutive instructions:
  - BEQ: 0→1→8.
  - J: 0→1→9.
  - R-type: 0→1→6→7.
  - LW: 0→1→2→3→4.
  - SW: 0→1→2→5.
- There is no handshake. The FSM paces everything and the unit never stalls.

## Configuration
- `FETCH_PERF_EN` defined:
  - `CycleCount` increments by 1 on every non-reset edge.
  - `InstrCount` increments by 1 on every non-reset edge where `State == 0`.
  - Both wrap from `32'hFFFF_FFFF` to 0.
- `FETCH_PERF_EN` undefined:
  - Both ports and counters are removed.
  - Remaining behaviour is bit-identical.

## Test plan
- **Reset:** with `RESET_PC = 32'h0000_0100`, assert Reset for 2 cycles while `State = 9` → `PC = 32'h100`, `IR = 0`, `Opcode = 0`, `BranchTarget = 0`.
- **Fetch:** `State = 0`, `MemData = 32'h8C43_0004` (LW) → next edge `PC = 32'h104`, `Opcode = 6'b100011`, `Rs = 2`, `Rt = 3`, `Imm = 32'h4`. Then hold `State = 2` for 3 cycles → PC and IR unchanged.
- **Backward branch taken:** from PC 0x100, fetch `32'h1022_FFFE` (BEQ, imm = −2) → state 1 gives `BranchTarget = 32'hFC`. State 8 with `Zero = 1` → `PC = 32'hFC`. Repeat with `Zero = 0` → `PC = 32'h104`.
- **Jump:** from PC 0x100, fetch `32'h0800_0040` (J) → state 9 gives `PC = 32'h0000_0100`. From `RESET_PC = 32'hF000_0000`, same word → `PC = 32'hF000_0100`.
- **PC wrap:** from `PC = 32'hFFFF_FFFC`, state 0 → `PC = 0`. Then `State = 12` for 2 cycles → all registers hold.
- **Perf counters (`FETCH_PERF_EN`):** run one R-type (states 0,1,6,7) plus one J (0,1,9) → `InstrCount = 2`, `CycleCount = 7`. Assert Reset in state 6 → both counters read 0.
